// File: rtl/mcoi_ps_snapshot_writer_pkg.sv
// Shared types and helpers for the PS shared-memory snapshot writer.
// The header word layout is defined here so the RTL and PS software agree on one packing.
package mcoi_ps_snapshot_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_WRITE   = 3'd2,
        ST_HEADER  = 3'd3,
        ST_COMMIT  = 3'd4
    } state_e;

    localparam logic [3:0] BYTE_EN_ALL  = 4'hF;
    localparam logic [7:0] OVERRUN_MAX  = 8'hFF;

    // Header: sequence number in the upper half, payload word count in the lower half.
    function automatic logic [31:0] pack_header(input logic [15:0] seq, input logic [15:0] count);
        return {seq, count};
    endfunction

endpackage

// File: rtl/mcoi_ps_snapshot_writer.sv
// Captures a block of status words on a trigger and writes it to one of two ping-pong pages
// of PS shared memory; payload first, header last, then publishes the page via a toggle.
module mcoi_ps_snapshot_writer
    import mcoi_ps_snapshot_writer_pkg::*;
#(
    parameter int unsigned NUM_WORDS  = 16,
    parameter logic [31:0] PAGE0_BASE = 32'h0000_0000,
    parameter logic [31:0] PAGE1_BASE = 32'h0000_0400,
    parameter int unsigned SEQ_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable_i,
    input  logic                   trigger_i,
    input  logic [NUM_WORDS*32-1:0] data_i,
    input  logic                   ack_tgl_i,
    output logic                   en_o,
    output logic [3:0]             we_o,
    output logic [31:0]            addr_o,
    output logic [31:0]            din_o,
    output logic                   busy_o,
    output logic                   page_o,
    output logic                   commit_tgl_o,
    output logic [SEQ_W-1:0]       seq_o,
    output logic [7:0]             overrun_o,
    output logic                   done_o
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

    state_e             state_q, state_d;
    logic [7:0]         idx_q, idx_d;
    logic               tp_q, tp_d;
    logic               page_q, page_d;
    logic               tgl_q, tgl_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [SEQ_W-1:0]   seq_inc;
    logic [7:0]         ovr_q, ovr_d;
    logic               en_q, en_d;
    logic [3:0]         we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        din_q, din_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [31:0]        data_words [NUM_WORDS];
    logic [31:0]        shadow_q   [NUM_WORDS];
    logic [31:0]        shadow_d   [NUM_WORDS];
    logic [31:0]        wr_word;
    logic [31:0]        page_base;
    logic               trig_req;
    logic               pending;
    logic               drop;

    // Shadow copy is taken while in CAPTURE; it needs no reset because it is always
    // rewritten before any of its words reach the bus.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_shadow
            assign data_words[gi] = data_i[32*gi +: 32];
            assign shadow_d[gi]   = (state_q == ST_CAPTURE) ? data_words[gi] : shadow_q[gi];

            always_ff @(posedge clk) begin
                shadow_q[gi] <= shadow_d[gi];
            end
        end
    endgenerate

    assign trig_req = trigger_i & enable_i;
    assign pending  = tgl_q ^ ack_tgl_i;
    assign drop     = trig_req & ((state_q != ST_IDLE) | pending);
    assign seq_inc  = seq_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tp_d    = tp_q;
        page_d  = page_q;
        tgl_d   = tgl_q;
        seq_d   = seq_q;
        ovr_d   = ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (trig_req && !pending) begin
                    state_d = ST_CAPTURE;
                    tp_d    = ~page_q;
                end
            end
            ST_CAPTURE: begin
                idx_d   = '0;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_HEADER;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            ST_HEADER: begin
                // Publish together with the COMMIT cycle; the header write has completed by then.
                state_d = ST_COMMIT;
                page_d  = tp_q;
                seq_d   = seq_inc;
                tgl_d   = ~tgl_q;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (drop && (ovr_q != OVERRUN_MAX)) begin
            ovr_d = ovr_q + 8'd1;
        end

        // Word 0 leaves in the same edge the shadow is loaded, so take it straight from the input.
        wr_word = '0;
        if (state_q == ST_CAPTURE) begin
            wr_word = data_words[0];
        end else begin
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (idx_d == 8'(k)) begin
                    wr_word = shadow_q[k];
                end
            end
        end

        page_base = tp_d ? PAGE1_BASE : PAGE0_BASE;
        en_d      = 1'b0;
        we_d      = '0;
        addr_d    = '0;
        din_d     = '0;
        case (state_d)
            ST_WRITE: begin
                en_d   = 1'b1;
                we_d   = BYTE_EN_ALL;
                addr_d = page_base + {22'd0, idx_d + 8'd1, 2'b00};
                din_d  = wr_word;
            end
            ST_HEADER: begin
                en_d   = 1'b1;
                we_d   = BYTE_EN_ALL;
                addr_d = page_base;
                din_d  = pack_header(16'(seq_inc), 16'(NUM_WORDS));
            end
            default: ;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_COMMIT);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            tp_q    <= 1'b0;
            page_q  <= 1'b0;
            tgl_q   <= 1'b0;
            seq_q   <= '0;
            ovr_q   <= '0;
            en_q    <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tp_q    <= tp_d;
            page_q  <= page_d;
            tgl_q   <= tgl_d;
            seq_q   <= seq_d;
            ovr_q   <= ovr_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign en_o         = en_q;
    assign we_o         = we_q;
    assign addr_o       = addr_q;
    assign din_o        = din_q;
    assign busy_o       = busy_q;
    assign page_o       = page_q;
    assign commit_tgl_o = tgl_q;
    assign seq_o        = seq_q;
    assign overrun_o    = ovr_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_mcoi_ps_snapshot_writer.sv
// Bench for the snapshot writer: a transaction-level model checked every cycle against the
// main instance, plus literal expectations and a small instance exercising sequence wrap.
module tb_mcoi_ps_snapshot_writer;

    localparam int NW = 16;
    localparam int CAP_K  = -2;
    localparam int IDLE_K = -3;
    localparam int HDR_K  = NW;
    localparam int COM_K  = NW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_n, enable_i, trigger_i, ack_tgl_i;
    logic [NW*32-1:0]    data_i;
    logic                en_o, busy_o, page_o, commit_tgl_o, done_o;
    logic [3:0]          we_o;
    logic [31:0]         addr_o, din_o;
    logic [15:0]         seq_o;
    logic [7:0]          overrun_o;

    logic                trigger2, ack2;
    logic [31:0]         data2;
    logic                en2, busy2, page2, tgl2, done2;
    logic [3:0]          we2;
    logic [31:0]         addr2, din2;
    logic [3:0]          seq2;
    logic [7:0]          ovr2;

    mcoi_ps_snapshot_writer #(
        .NUM_WORDS(NW), .PAGE0_BASE(32'h0000_0000), .PAGE1_BASE(32'h0000_0400), .SEQ_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .trigger_i(trigger_i),
        .data_i(data_i), .ack_tgl_i(ack_tgl_i), .en_o(en_o), .we_o(we_o), .addr_o(addr_o),
        .din_o(din_o), .busy_o(busy_o), .page_o(page_o), .commit_tgl_o(commit_tgl_o),
        .seq_o(seq_o), .overrun_o(overrun_o), .done_o(done_o)
    );

    mcoi_ps_snapshot_writer #(
        .NUM_WORDS(1), .PAGE0_BASE(32'h0000_0000), .PAGE1_BASE(32'h0000_0400), .SEQ_W(4)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .enable_i(1'b1), .trigger_i(trigger2),
        .data_i(data2), .ack_tgl_i(ack2), .en_o(en2), .we_o(we2), .addr_o(addr2),
        .din_o(din2), .busy_o(busy2), .page_o(page2), .commit_tgl_o(tgl2),
        .seq_o(seq2), .overrun_o(ovr2), .done_o(done2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          sched[$];
    int          cur_kind = IDLE_K;
    logic [31:0] snap [NW];
    logic        m_page = 1'b0, m_tgl = 1'b0, m_tp = 1'b0;
    logic [15:0] m_seq = '0;
    logic [7:0]  m_ovr = '0;
    logic        e_en = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic [3:0]  e_we = '0;
    logic [31:0] e_addr = '0, e_din = '0, e_base;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) begin
                sched.delete();
                cur_kind = IDLE_K;
                m_page = 1'b0; m_tgl = 1'b0; m_seq = '0; m_ovr = '0;
            end else begin
                if (cur_kind == CAP_K)
                    for (int k = 0; k < NW; k++) snap[k] = data_i[32*k +: 32];
                if (trigger_i && enable_i) begin
                    if (cur_kind != IDLE_K || (m_tgl ^ ack_tgl_i)) begin
                        if (m_ovr != 8'd255) m_ovr = m_ovr + 8'd1;
                    end else begin
                        m_tp = ~m_page;
                        sched.push_back(CAP_K);
                        for (int k = 0; k < NW; k++) sched.push_back(k);
                        sched.push_back(HDR_K);
                        sched.push_back(COM_K);
                    end
                end
                cur_kind = (sched.size() > 0) ? sched.pop_front() : IDLE_K;
                if (cur_kind == COM_K) begin
                    m_page = m_tp; m_seq = m_seq + 16'd1; m_tgl = ~m_tgl;
                end
            end
            e_base = m_tp ? 32'h0000_0400 : 32'h0000_0000;
            e_busy = (cur_kind != IDLE_K);
            e_done = (cur_kind == COM_K);
            e_en   = (cur_kind >= 0) && (cur_kind <= HDR_K);
            e_we   = e_en ? 4'hF : 4'h0;
            e_addr = '0;
            e_din  = '0;
            if (cur_kind >= 0 && cur_kind < NW) begin
                e_addr = e_base + 32'(4 * (cur_kind + 1));
                e_din  = snap[cur_kind];
            end else if (cur_kind == HDR_K) begin
                e_addr = e_base;
                e_din  = {m_seq + 16'd1, 16'(NW)};
            end
        end
    end

    // ---------------- monitor / per-cycle compare ----------------
    logic [63:0] bus_log[$];
    logic [31:0] hdr2;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cyc > 1) begin
                chk("cycle_ctrl",
                    {31'd0, busy_o, done_o, en_o, we_o, page_o, commit_tgl_o, overrun_o, seq_o},
                    {31'd0, e_busy, e_done, e_en, e_we, m_page, m_tgl, m_ovr, m_seq});
                chk("cycle_bus", {addr_o, din_o}, {e_addr, e_din});
            end
            if (en_o) bus_log.push_back({addr_o, din_o});
            if (en2 && addr2[9:0] == 10'd0) hdr2 = din2;
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input bit which, output int t);
        @(negedge clk);
        if (which) trigger2 = 1'b1; else trigger_i = 1'b1;
        t = cyc;
        @(negedge clk);
        trigger_i = 1'b0;
        trigger2  = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which ? done2 : done_o) === 1'b1) begin
                at = cyc;
                break;
            end
        end
        n_checks++;
        if (at < 0) begin
            n_fail++;
            $display("FAIL done_timeout cyc=%0d actual=none required=done within %0d", cyc, budget);
        end
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int k = 0; k < NW; k++) data_i[32*k +: 32] = base + 32'(k);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    int t0, td;
    logic [3:0] s4;

    initial begin
        reset_n = 1'b0; enable_i = 1'b0; trigger_i = 1'b0; ack_tgl_i = 1'b0;
        trigger2 = 1'b0; ack2 = 1'b0; data2 = 32'hC0DE_0001;
        set_data(32'hA500_0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {en_o, busy_o, done_o, page_o, commit_tgl_o, we_o, addr_o},
            {3'b000, 2'b00, 4'h0, 32'h0});
        chk("reset_counters", {overrun_o, seq_o}, 24'h0);

        // first snapshot to page 1
        enable_i = 1'b1;
        bus_log.delete();
        pulse(1'b0, t0);
        wait_done(1'b0, 40, td);
        chk("t1_latency", 64'(td - t0), 64'd19);
        @(negedge clk);
        chk("t1_count", 64'(bus_log.size()), 64'd17);
        if (bus_log.size() == 17) begin
            chk("t1_first", bus_log[0],  {32'h0000_0404, 32'hA500_0000});
            chk("t1_last",  bus_log[15], {32'h0000_0440, 32'hA500_000F});
            chk("t1_header", bus_log[16], {32'h0000_0400, 32'h0001_0010});
        end
        chk("t1_publish", {page_o, commit_tgl_o, seq_o}, {1'b1, 1'b1, 16'd1});

        // second snapshot after ack, to page 0
        ack_tgl_i = 1'b1;
        bus_log.delete();
        pulse(1'b0, t0);
        wait_done(1'b0, 40, td);
        @(negedge clk);
        if (bus_log.size() == 17) begin
            chk("t2_first", bus_log[0],  {32'h0000_0004, 32'hA500_0000});
            chk("t2_header", bus_log[16], {32'h0000_0000, 32'h0002_0010});
        end else chk("t2_count", 64'(bus_log.size()), 64'd17);
        chk("t2_publish", {page_o, seq_o}, {1'b0, 16'd2});

        // unacked trigger is dropped
        ack_tgl_i = 1'b1;
        @(negedge clk);
        ack_tgl_i = 1'b0;
        @(negedge clk);
        ack_tgl_i = 1'b1;
        @(negedge clk);
        bus_log.delete();
        ack_tgl_i = 1'b1;
        // commit_tgl_o is 0 here, so ack=1 leaves the page pending
        ack_tgl_i = 1'b1;
        pulse(1'b0, t0);
        repeat (25) @(negedge clk);
        chk("t3_no_bus", 64'(bus_log.size()), 64'd0);
        chk("t3_overrun", 64'(overrun_o), 64'd1);

        // trigger during WRITE, data changes after CAPTURE
        ack_tgl_i = 1'b0;
        bus_log.delete();
        pulse(1'b0, t0);
        @(negedge clk);
        set_data(32'h5A5A_0000);
        repeat (3) @(negedge clk);
        trigger_i = 1'b1;
        @(negedge clk);
        trigger_i = 1'b0;
        wait_done(1'b0, 40, td);
        @(negedge clk);
        chk("t4_overrun", 64'(overrun_o), 64'd2);
        if (bus_log.size() == 17) begin
            chk("t4_word0", bus_log[0], {32'h0000_0404, 32'hA500_0000});
            chk("t4_word8", bus_log[8], {32'h0000_0424, 32'hA500_0008});
            chk("t4_header", bus_log[16], {32'h0000_0400, 32'h0003_0010});
        end else chk("t4_count", 64'(bus_log.size()), 64'd17);
        chk("t4_publish", {page_o, seq_o}, {1'b1, 16'd3});

        // 300 unacked triggers saturate overrun
        set_data(32'hA500_0000);
        bus_log.delete();
        @(negedge clk);
        trigger_i = 1'b1;
        repeat (300) @(negedge clk);
        trigger_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_saturate", 64'(overrun_o), 64'd255);
        chk("t3_sat_no_bus", 64'(bus_log.size()), 64'd0);

        // reset in the middle of a snapshot
        ack_tgl_i = 1'b1;
        pulse(1'b0, t0);
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("t5_after_reset", {en_o, busy_o, page_o, commit_tgl_o, overrun_o, seq_o},
            {4'b0000, 8'd0, 16'd0});
        ack_tgl_i = 1'b0;
        bus_log.delete();
        pulse(1'b0, t0);
        wait_done(1'b0, 40, td);
        @(negedge clk);
        if (bus_log.size() == 17)
            chk("t5_header", bus_log[16], {32'h0000_0400, 32'h0001_0010});
        else chk("t5_count", 64'(bus_log.size()), 64'd17);
        chk("t5_publish", {page_o, seq_o}, {1'b1, 16'd1});

        // disabled trigger does nothing
        ack_tgl_i = 1'b1;
        enable_i  = 1'b0;
        bus_log.delete();
        pulse(1'b0, t0);
        repeat (25) @(negedge clk);
        chk("t6_no_bus", 64'(bus_log.size()), 64'd0);
        chk("t6_no_overrun", 64'(overrun_o), 64'd0);
        enable_i = 1'b1;

        // small instance: one word, 4-bit sequence wraps 15 -> 0
        for (int i = 0; i < 16; i++) begin
            pulse(1'b1, t0);
            wait_done(1'b1, 10, td);
            if (i == 0) chk("w_latency", 64'(td - t0), 64'd4);
            ack2 = ~ack2;
            @(negedge clk);
            s4 = 4'(i + 1);
            chk("w_seq", 64'(seq2), 64'(s4));
            chk("w_page", 64'(page2), 64'((i % 2) == 0));
            chk("w_header", 64'(hdr2), {32'd0, 12'd0, s4, 16'd1});
        end
        chk("w_no_overrun", 64'(ovr2), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mcoi_ps_snapshot_writer.md
Name: mcoi_ps_snapshot_writer

Overview:
- Upstream master of the PS shared-memory BRAM port in the 40 MHz domain.
- On a trigger it latches a block of application status words and writes them into one of two ping-pong pages of PS shared memory.
- It then writes a header word and publishes the page to the PS.
- A toggle handshake with the PS prevents overwriting a page the PS has not yet consumed.

Parameters:
- NUM_WORDS, 16, payload words per snapshot (1..255).
- PAGE0_BASE, 32'h0000_0000, byte address of page 0.
- PAGE1_BASE, 32'h0000_0400, byte address of page 1; requires 4*(NUM_WORDS+1) <= PAGE1_BASE-PAGE0_BASE.
- SEQ_W, 16, sequence counter width.

Ports:
- clk  in  1  40 MHz clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- enable_i  in  1  PS control bit; triggers are ignored when low.
- trigger_i  in  1  single-cycle snapshot request.
- data_i  in  NUM_WORDS*32  flattened status words; word k = data_i[32k+31:32k].
- ack_tgl_i  in  1  PS acknowledge toggle, synchronous to clk.
- en_o  out  1  BRAM port enable.
- we_o  out  4  BRAM byte write enables.
- addr_o  out  32  BRAM byte address.
- din_o  out  32  BRAM write data.
- busy_o  out  1  high outside IDLE.
- page_o  out  1  last published page.
- commit_tgl_o  out  1  toggles on every publish.
- seq_o  out  SEQ_W  sequence number of last published snapshot.
- overrun_o  out  8  saturating count of dropped triggers.
- done_o  out  1  one-cycle pulse on publish.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State = IDLE.
  - All outputs 0; page_o=0, commit_tgl_o=0, seq_o=0, overrun_o=0.
  - Shadow register contents don't-care.
  - A reset mid-write abandons the write; page_o is unchanged from its reset value, so the partial page is never published.
- pending = commit_tgl_o XOR ack_tgl_i. The PS writes ack_tgl_i := commit_tgl_o after reading the published page.
- IDLE, trigger_i=1, enable_i=0: trigger ignored, no count.
- IDLE, trigger_i=1, enable_i=1, pending=1: trigger dropped; overrun_o++ (saturates at 255).
- IDLE, trigger_i=1, enable_i=1, pending=0: go to CAPTURE. Target page tp = ~page_o.
- CAPTURE (1 cycle): latch data_i into the shadow register; word index i=0; go to WRITE.
- WRITE:
  - Each cycle: en_o=1, we_o=4'hF, addr_o=base(tp)+4*(i+1), din_o=shadow[i].
  - When i=NUM_WORDS-1, go to HEADER.
- HEADER (1 cycle):
  - en_o=1, we_o=4'hF, addr_o=base(tp).
  - din_o = {seq_o+1 truncated/zero-extended to 16 bits, 16'(NUM_WORDS)}.
  - Go to COMMIT.
- COMMIT (1 cycle):
  - page_o<=tp, seq_o<=seq_o+1 (wraps modulo 2^SEQ_W), commit_tgl_o<=~commit_tgl_o.
  - done_o=1; go to IDLE.
- Outside WRITE/HEADER: en_o=0, we_o=0; addr_o and din_o hold 0.
- Latency: trigger at cycle T → CAPTURE T+1 → writes T+2..T+NUM_WORDS+1 → header T+NUM_WORDS+2 → done_o at T+NUM_WORDS+3.
- The header is written last, so a header read by the PS always describes a complete page.
- Triggers while busy_o=1 are dropped and counted in overrun_o, regardless of pending.
- enable_i falling mid-snapshot: the current snapshot completes and publishes.
- The trigger in the COMMIT cycle counts as busy (dropped). A trigger in the cycle after COMMIT sees pending=1 unless ack_tgl_i has already toggled.
- The block never reads BRAM dout.

Decomposition:
- Shared package (MCPkg): state enum (IDLE, CAPTURE, WRITE, HEADER, COMMIT) and a header-pack function (seq, count) → 32 bits.
- Single module with a flat FSM plus index counter; no sub-module is warranted.

Test Plan:
- Reset, then enable_i=1, trigger with NUM_WORDS=16 and data word k = 32'hA500_0000+k:
  - 16 writes to 0x404..0x440 with matching data, then header 0x0001_0010 at 0x400.
  - done_o at T+19; page_o=1, seq_o=1, commit_tgl_o=1.
- Set ack_tgl_i=1 and trigger again:
  - writes go to 0x004..0x040, header 0x0002_0010 at 0x000; page_o=0, seq_o=2.
- Trigger without toggling ack:
  - no BRAM activity, overrun_o=1; 300 further unacked triggers leave overrun_o=255.
- Trigger during WRITE (cycle T+5):
  - overrun_o increments; the first snapshot completes unaltered; data_i changes after CAPTURE do not appear in memory.
- reset_n=0 at T+8 of a snapshot, then released:
  - en_o=0, page_o=0, seq_o=0, overrun_o=0; the next trigger writes page 1 with seq 1.
- enable_i=0 with a trigger: no activity, no overrun. Force seq_o=16'hFFFF then complete a snapshot: seq_o wraps to 0.
